// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO write in one edge.
// Divide by zero bypasses the iteration and completes on the following edge.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               is_div_reg;
  logic               raw_reg;       // result already final (divide by zero)
  logic               neg_res_reg;   // operand signs differ
  logic               neg_rem_reg;   // dividend was negative
  logic [WIDTH-1:0]   opnd_reg;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_reg;       // {upper, lower}: product, or {remainder, quotient}
  logic [CW-1:0]      count_reg;

  // Operand decode and magnitudes
  logic               op_signed;
  logic               op_is_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     a_mag;
  logic [WIDTH:0]     b_mag;

  // Iteration step and sign fix-up results
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes are formed in WIDTH+1 bits so the most-negative value is exact
  always_comb begin
    op_signed = ~op[0];
    op_is_div = op[1];
    a_ext     = op_signed ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext     = op_signed ? {b[WIDTH-1], b} : {1'b0, b};
    a_neg     = a_ext[WIDTH];
    b_neg     = b_ext[WIDTH];
    a_mag     = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag     = b_neg ? (~b_ext + 1'b1) : b_ext;
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_sub   = div_shift - {1'b0, opnd_reg};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    div_next  = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_reg[WIDTH-2:0], div_ge};
  end

  // Sign fix-up of the unsigned magnitudes
  always_comb begin
    prod_fix = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
    quo_fix  = neg_res_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    rem_fix  = neg_rem_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                           : acc_reg[2*WIDTH-1:WIDTH];
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      is_div_reg  <= 1'b0;
      raw_reg     <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      opnd_reg    <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (flush && state_reg != IDLE) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !flush) begin
              if (!op[2]) begin
                busy_reg    <= 1'b1;
                is_div_reg  <= op_is_div;
                neg_res_reg <= a_neg ^ b_neg;
                neg_rem_reg <= a_neg;
                count_reg   <= '0;
                if (op_is_div && b == '0) begin
                  raw_reg   <= 1'b1;
                  acc_reg   <= {a, {WIDTH{1'b1}}};
                  state_reg <= FIX;
                end else begin
                  raw_reg   <= 1'b0;
                  opnd_reg  <= op_is_div ? b_mag[WIDTH-1:0] : a_mag[WIDTH-1:0];
                  acc_reg   <= {{WIDTH{1'b0}},
                                (op_is_div ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0])};
                  state_reg <= CALC;
                end
              end else if (op == 3'b100) begin
                hi_reg <= a;
              end else if (op == 3'b101) begin
                lo_reg <= a;
              end
            end
          end
          CALC: begin
            acc_reg   <= is_div_reg ? div_next : mul_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == CW'(WIDTH - 1)) begin
              state_reg <= FIX;
            end
          end
          FIX: begin
            if (raw_reg) begin
              hi_reg <= acc_reg[2*WIDTH-1:WIDTH];
              lo_reg <= acc_reg[WIDTH-1:0];
            end else if (is_div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end else begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
